// File: rtl/cricket_pkg.sv
// Shared types for the cricket innings logic: ball outcome codes, FSM states
// and the runs credited for each outcome.
// Pure declarations, no timing or flow control.
package cricket_pkg;

    typedef enum logic [3:0] {
        OUT_NONE   = 4'd0,
        OUT_DOT    = 4'd1,
        OUT_ONE    = 4'd2,
        OUT_TWO    = 4'd3,
        OUT_THREE  = 4'd4,
        OUT_FOUR   = 4'd5,
        OUT_SIX    = 4'd6,
        OUT_WIDE   = 4'd7,
        OUT_NOBALL = 4'd8,
        OUT_WICKET = 4'd9
    } outcome_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_t;

    // Runs credited to the batting side; extras (wide/no-ball) are worth one.
    function automatic logic [2:0] run_value(input outcome_t o);
        case (o)
            OUT_ONE:    run_value = 3'd1;
            OUT_TWO:    run_value = 3'd2;
            OUT_THREE:  run_value = 3'd3;
            OUT_FOUR:   run_value = 3'd4;
            OUT_SIX:    run_value = 3'd6;
            OUT_WIDE:   run_value = 3'd1;
            OUT_NOBALL: run_value = 3'd1;
            default:    run_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/cricket_outcome_decode.sv
// Maps a sampled 4-bit LFSR word to a ball outcome, its run value and flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, consumed only when the FSM updates.
module cricket_outcome_decode
    import cricket_pkg::*;
(
    input  logic [3:0] samp_i,
    output outcome_t   outcome_o,
    output logic [2:0] run_add_o,
    output logic       legal_o,
    output logic       is_wkt_o
);

    // Weighted decode: low codes favour dots and singles, top codes are the rare events.
    always_comb begin
        outcome_o = OUT_DOT;
        if (samp_i <= 4'd2)       outcome_o = OUT_DOT;
        else if (samp_i <= 4'd6)  outcome_o = OUT_ONE;
        else if (samp_i <= 4'd9)  outcome_o = OUT_TWO;
        else if (samp_i == 4'd10) outcome_o = OUT_THREE;
        else if (samp_i == 4'd11) outcome_o = OUT_FOUR;
        else if (samp_i == 4'd12) outcome_o = OUT_SIX;
        else if (samp_i == 4'd13) outcome_o = OUT_WIDE;
        else if (samp_i == 4'd14) outcome_o = OUT_NOBALL;
        else                      outcome_o = OUT_WICKET;
    end

    assign run_add_o = run_value(outcome_o);
    assign legal_o   = (outcome_o != OUT_WIDE) && (outcome_o != OUT_NOBALL);
    assign is_wkt_o  = (outcome_o == OUT_WICKET);

endmodule

// File: rtl/innings_controller.sv
// Sequences one innings: bowl request -> sample LFSR -> score update -> hold -> next ball or end.
// Latency: result_valid 2 cycles after the request cycle; busy lasts 2+HOLD_CYCLES cycles.
// Backpressure: none; requests while busy or after the innings ends are dropped, never queued.
// Optional feature macro: FREE_HIT_EN (no-ball grants a free hit that cancels the next wicket).
module innings_controller
    import cricket_pkg::*;
#(
    parameter int unsigned MAX_OVERS      = 20,
    parameter int unsigned BALLS_PER_OVER = 6,
    parameter int unsigned MAX_WICKETS    = 10,
    parameter int unsigned HOLD_CYCLES    = 100_000_000,
    parameter int unsigned RUN_W          = 10
) (
    input  logic             clk_fpga,
    input  logic             reset,
    input  logic             delivery,
    input  logic [3:0]       lfsr_q,
    output logic             busy,
    output logic             result_valid,
    output logic [3:0]       outcome,
    output logic [RUN_W-1:0] runs,
    output logic [3:0]       wickets,
    output logic [4:0]       overs,
    output logic [2:0]       balls,
    output logic             innings_over,
    output logic             free_hit
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned SUM_W  = RUN_W + 3;

    logic              dly_q;
    logic              req;
    state_t            state_q, state_d;
    logic              samp_en, upd_en;
    logic [3:0]        samp_q;
    logic [HOLD_W-1:0] hold_q;
    logic              hold_done;

    outcome_t          dec_outcome;
    logic [2:0]        dec_add;
    logic              dec_legal, dec_wkt;

    outcome_t          eff_outcome;
    logic [2:0]        eff_add;
    logic              eff_legal, eff_wkt;
    logic [SUM_W-1:0]  runs_sum;

    outcome_t          outcome_q, outcome_d;
    logic [RUN_W-1:0]  runs_q, runs_d;
    logic [3:0]        wkts_q, wkts_d;
    logic [4:0]        overs_q, overs_d;
    logic [2:0]        balls_q, balls_d;
    logic              over_q, over_d;
    logic              rv_q;

    // Rising-edge detector on the debounced button, tracked in every state.
    always_ff @(posedge clk_fpga) begin
        if (reset) dly_q <= 1'b0;
        else       dly_q <= delivery;
    end
    assign req = delivery & ~dly_q;

    cricket_outcome_decode u_decode (
        .samp_i    (samp_q),
        .outcome_o (dec_outcome),
        .run_add_o (dec_add),
        .legal_o   (dec_legal),
        .is_wkt_o  (dec_wkt)
    );

    // FSM state register.
    always_ff @(posedge clk_fpga) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // SHOW covers the result_valid cycle plus HOLD_CYCLES further cycles.
    assign hold_done = (hold_q == HOLD_W'(HOLD_CYCLES));

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req && !over_q) state_d = EVAL;
            EVAL: state_d = SHOW;
            SHOW: if (hold_done) state_d = over_q ? DONE : IDLE;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy flag, sample strobe and score-update strobe.
    always_comb begin
        busy    = (state_q != IDLE);
        samp_en = (state_q == IDLE) && req && !over_q;
        upd_en  = (state_q == EVAL);
    end

    // Capture the LFSR word on the accepted request.
    always_ff @(posedge clk_fpga) begin
        if (reset)        samp_q <= 4'd0;
        else if (samp_en) samp_q <= lfsr_q;
    end

    // Display hold counter, restarted on every evaluation.
    always_ff @(posedge clk_fpga) begin
        if (reset)                 hold_q <= '0;
        else if (state_q == EVAL)  hold_q <= '0;
        else if (state_q == SHOW)  hold_q <= hold_q + HOLD_W'(1);
    end

`ifdef FREE_HIT_EN
    logic fh_q, fh_d;

    // Free-hit flag: armed by a no-ball, kept across wides, consumed by any legal ball.
    always_comb begin
        fh_d = fh_q;
        if (eff_outcome == OUT_NOBALL) fh_d = 1'b1;
        else if (eff_legal)            fh_d = 1'b0;
    end

    // Free-hit register, updated alongside the score.
    always_ff @(posedge clk_fpga) begin
        if (reset)       fh_q <= 1'b0;
        else if (upd_en) fh_q <= fh_d;
    end

    assign free_hit = fh_q;
`else
    assign free_hit = 1'b0;
`endif

    // Next score: apply free-hit override, saturating runs, ball/over roll, end-of-innings test.
    always_comb begin
        eff_outcome = dec_outcome;
        eff_add     = dec_add;
        eff_legal   = dec_legal;
        eff_wkt     = dec_wkt;
`ifdef FREE_HIT_EN
        if (fh_q && dec_wkt) begin
            eff_outcome = OUT_DOT;
            eff_add     = 3'd0;
            eff_legal   = 1'b1;
            eff_wkt     = 1'b0;
        end
`endif
        outcome_d = eff_outcome;
        runs_sum  = SUM_W'(runs_q) + SUM_W'(eff_add);
        runs_d    = (runs_sum > SUM_W'({RUN_W{1'b1}})) ? {RUN_W{1'b1}} : runs_sum[RUN_W-1:0];
        wkts_d    = wkts_q + {3'd0, eff_wkt};
        balls_d   = balls_q;
        overs_d   = overs_q;
        if (eff_legal) begin
            if (balls_q == 3'(BALLS_PER_OVER - 1)) begin
                balls_d = 3'd0;
                overs_d = overs_q + 5'd1;
            end else begin
                balls_d = balls_q + 3'd1;
            end
        end
        over_d = over_q || (wkts_d == 4'(MAX_WICKETS)) || (overs_d == 5'(MAX_OVERS));
    end

    // Score registers and the one-cycle result pulse.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            outcome_q <= OUT_NONE;
            runs_q    <= '0;
            wkts_q    <= 4'd0;
            overs_q   <= 5'd0;
            balls_q   <= 3'd0;
            over_q    <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            rv_q <= upd_en;
            if (upd_en) begin
                outcome_q <= outcome_d;
                runs_q    <= runs_d;
                wkts_q    <= wkts_d;
                overs_q   <= overs_d;
                balls_q   <= balls_d;
                over_q    <= over_d;
            end
        end
    end

    assign result_valid = rv_q;
    assign outcome      = outcome_q;
    assign runs         = runs_q;
    assign wickets      = wkts_q;
    assign overs        = overs_q;
    assign balls        = balls_q;
    assign innings_over = over_q;

endmodule

// File: tb/tb_innings_controller.sv
// Self-checking bench for innings_controller: table-driven balls with a result scoreboard,
// plus hand-written sequences for dropped/held requests, reset mid-ball and run saturation.
module tb_innings_controller;
    import cricket_pkg::*;

    localparam int HOLD = 4;

    logic       clk_fpga = 1'b0;
    logic       reset    = 1'b1;
    logic       delivery = 1'b0;
    logic       delivery2 = 1'b0;
    logic [3:0] lfsr_q   = 4'd0;

    logic       busy, result_valid, innings_over, free_hit;
    logic [3:0] outcome, wickets;
    logic [9:0] runs;
    logic [4:0] overs;
    logic [2:0] balls;

    logic       busy2, result_valid2, innings_over2, free_hit2;
    logic [3:0] outcome2, wickets2;
    logic [3:0] runs2;
    logic [4:0] overs2;
    logic [2:0] balls2;

    innings_controller #(
        .MAX_OVERS(2), .BALLS_PER_OVER(6), .MAX_WICKETS(2), .HOLD_CYCLES(HOLD), .RUN_W(10)
    ) dut (
        .clk_fpga(clk_fpga), .reset(reset), .delivery(delivery), .lfsr_q(lfsr_q),
        .busy(busy), .result_valid(result_valid), .outcome(outcome), .runs(runs),
        .wickets(wickets), .overs(overs), .balls(balls), .innings_over(innings_over),
        .free_hit(free_hit)
    );

    innings_controller #(
        .MAX_OVERS(20), .BALLS_PER_OVER(6), .MAX_WICKETS(15), .HOLD_CYCLES(HOLD), .RUN_W(4)
    ) dut_sat (
        .clk_fpga(clk_fpga), .reset(reset), .delivery(delivery2), .lfsr_q(lfsr_q),
        .busy(busy2), .result_valid(result_valid2), .outcome(outcome2), .runs(runs2),
        .wickets(wickets2), .overs(overs2), .balls(balls2), .innings_over(innings_over2),
        .free_hit(free_hit2)
    );

    always #5 clk_fpga = ~clk_fpga;

    typedef struct {
        logic [3:0] lfsr;
        int outc;
        int runs;
        int wkts;
        int overs;
        int balls;
        int over;
        int fh;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic [3:0] l, input int o, input int r, input int w,
                                input int ov, input int b, input int io, input int fh);
        vec_t v;
        v.lfsr = l; v.outc = o; v.runs = r; v.wkts = w;
        v.overs = ov; v.balls = b; v.over = io; v.fh = fh;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk_fpga) begin
        if (!reset && result_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result_valid: got pulse, expected none (t=%0t)", $time);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("outcome", int'(outcome), e.outc);
                chk("runs", int'(runs), e.runs);
                chk("wickets", int'(wickets), e.wkts);
                chk("overs", int'(overs), e.overs);
                chk("balls", int'(balls), e.balls);
                chk("innings_over", int'(innings_over), e.over);
                chk("free_hit", int'(free_hit), e.fh);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk_fpga); #1;
        reset = 1'b1; delivery = 1'b0; delivery2 = 1'b0;
        repeat (2) @(posedge clk_fpga);
        #1 reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rv"}, int'(result_valid), 0);
        chk({tag, "_outcome"}, int'(outcome), int'(OUT_NONE));
        chk({tag, "_runs"}, int'(runs), 0);
        chk({tag, "_wickets"}, int'(wickets), 0);
        chk({tag, "_overs"}, int'(overs), 0);
        chk({tag, "_balls"}, int'(balls), 0);
        chk({tag, "_over"}, int'(innings_over), 0);
        chk({tag, "_free_hit"}, int'(free_hit), 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(posedge clk_fpga); #1;
        end
        chk({tag, "_idle_timeout"}, int'(busy), 0);
    endtask

    // One ball: single-cycle press, expectation queued, latency and busy length checked.
    task automatic ball(input vec_t e, input bit expect_done);
        int n;
        @(posedge clk_fpga); #1;
        lfsr_q = e.lfsr; delivery = 1'b1;
        sb.push_back(e);
        @(posedge clk_fpga); #1;
        delivery = 1'b0;
        n = 0;
        while (busy && n < HOLD + 10) begin
            n++;
            if (n == 1) chk("rv_before_latency", int'(result_valid), 0);
            if (n == 2) chk("rv_at_latency", int'(result_valid), 1);
            @(posedge clk_fpga); #1;
        end
        if (expect_done) chk("done_stays_busy", int'(busy), 1);
        else             chk("busy_cycles", n, HOLD + 2);
    endtask

    initial begin
        // Test 2 and test 5 vectors.
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(4'd3, OUT_ONE, i + 1, 0, (i == 5) ? 1 : 0, (i + 1) % 6, 0, 0));
        tbl.push_back(mk(4'd13, OUT_WIDE, 7, 0, 1, 0, 0, 0));
`ifdef FREE_HIT_EN
        tbl.push_back(mk(4'd14, OUT_NOBALL, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'd13, OUT_WIDE,   2, 0, 0, 0, 0, 1));
        tbl.push_back(mk(4'd15, OUT_DOT,    2, 0, 0, 1, 0, 0));
`else
        tbl.push_back(mk(4'd14, OUT_NOBALL, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd13, OUT_WIDE,   2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd15, OUT_WICKET, 2, 1, 0, 1, 0, 0));
`endif

        // Reset state.
        repeat (3) @(posedge clk_fpga);
        #1 reset = 1'b0;
        check_zero("reset");

        // Test 1: a boundary four.
        ball(mk(4'd11, OUT_FOUR, 4, 0, 0, 1, 0, 0), 1'b0);

        // Test 2: an over of singles then a wide.
        do_reset();
        for (int i = 0; i < 7; i++) ball(tbl[i], 1'b0);

        // Test 3: two wickets end the innings; later presses are ignored.
        do_reset();
        ball(mk(4'd15, OUT_WICKET, 0, 1, 0, 1, 0, 0), 1'b0);
        ball(mk(4'd15, OUT_WICKET, 0, 2, 0, 2, 1, 0), 1'b1);
        @(posedge clk_fpga); #1 delivery = 1'b1;
        @(posedge clk_fpga); #1 delivery = 1'b0;
        repeat (HOLD + 4) @(posedge clk_fpga);
        #1;
        chk("done_after_press_busy", int'(busy), 1);
        chk("done_after_press_wickets", int'(wickets), 2);

        // Test 4: two full overs of dots end the innings.
        do_reset();
        for (int i = 1; i <= 12; i++)
            ball(mk(4'd0, OUT_DOT, 0, 0, i / 6, i % 6, (i == 12) ? 1 : 0, 0), i == 12);

        // Press during SHOW is dropped.
        do_reset();
        @(posedge clk_fpga); #1;
        lfsr_q = 4'd3; delivery = 1'b1;
        sb.push_back(mk(4'd3, OUT_ONE, 1, 0, 0, 1, 0, 0));
        @(posedge clk_fpga); #1 delivery = 1'b0;
        @(posedge clk_fpga); #1;
        @(posedge clk_fpga); #1;
        lfsr_q = 4'd11; delivery = 1'b1;
        @(posedge clk_fpga); #1 delivery = 1'b0;
        wait_idle("show_drop");
        repeat (HOLD + 4) @(posedge clk_fpga);
        #1;
        chk("show_drop_runs", int'(runs), 1);
        chk("show_drop_balls", int'(balls), 1);

        // Holding the button down bowls exactly one ball.
        @(posedge clk_fpga); #1;
        lfsr_q = 4'd4; delivery = 1'b1;
        sb.push_back(mk(4'd4, OUT_ONE, 2, 0, 0, 2, 0, 0));
        repeat (3 * (HOLD + 2)) @(posedge clk_fpga);
        #1;
        chk("held_runs", int'(runs), 2);
        chk("held_balls", int'(balls), 2);
        chk("held_idle", int'(busy), 0);
        delivery = 1'b0;
        repeat (2) @(posedge clk_fpga);

        // Reset while in EVAL aborts the ball without a pulse.
        #1;
        lfsr_q = 4'd11; delivery = 1'b1;
        @(posedge clk_fpga); #1;
        chk("eval_busy", int'(busy), 1);
        reset = 1'b1; delivery = 1'b0;
        @(posedge clk_fpga); #1;
        reset = 1'b0;
        check_zero("eval_reset");
        repeat (HOLD + 4) @(posedge clk_fpga);
        #1;
        chk("eval_reset_runs_later", int'(runs), 0);

        // Test 5: no-ball, wide, then a wicket code.
        do_reset();
        for (int i = 7; i < 10; i++) ball(tbl[i], 1'b0);

        // Test 6: sixes saturate a 4-bit runs counter.
        do_reset();
        lfsr_q = 4'd12;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_fpga); #1 delivery2 = 1'b1;
            @(posedge clk_fpga); #1 delivery2 = 1'b0;
            repeat (HOLD + 4) @(posedge clk_fpga);
            #1;
            chk("sat_runs", int'(runs2), (k == 0) ? 6 : (k == 1) ? 12 : 15);
        end

        repeat (2) @(posedge clk_fpga);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
